instruction_prefetch_buffer: RTL and testbench

INSTRUCTION_PREFETCH_BUFFER -- requirements
Module: instruction_prefetch_buffer

---
 rtl/proc_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 44 ++++
 rtl/instruction_prefetch_buffer.sv | 61 ++++++
 tb/tb_instruction_prefetch_buffer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: default address/instruction widths and opcodes.
package proc_pkg;

  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_JMP = 2'b11
  } opcode_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/clear, occupancy count and combinational head read.
module fetch_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head_ptr;
  logic [PTR_W-1:0]  tail_ptr;

  // Pointers wrap naturally; count alone tells full from empty.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (pop)  head_ptr <= head_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // When full, tail == head: the old head is read out the same cycle it is overwritten.
  always_ff @(posedge clk) begin
    if (rst && !clear && push) mem[tail_ptr] <= wdata;
  end

  assign head = mem[head_ptr];

endmodule

// File: rtl/instruction_prefetch_buffer.sv
// Prefetches sequential instructions into a small FIFO; a flush redirects fetch and empties it.
module instruction_prefetch_buffer #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = proc_pkg::ADDR_W,
  parameter int INSTR_W = proc_pkg::INSTR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic [INSTR_W-1:0]      imem_data,
  input  logic                    flush,
  input  logic [ADDR_W-1:0]       flush_addr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INSTR_W-1:0]      out_instr,
  output logic [ADDR_W-1:0]       out_pc,
  output logic [$clog2(DEPTH):0]  count
);

  import proc_pkg::*;

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int DATA_W = ADDR_W + INSTR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready && !flush;
  assign push      = ((count < DEPTH_C) || pop) && !flush;
  assign imem_addr = fetch_pc;

  // fetch_pc wraps silently at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (!rst)      fetch_pc <= '0;
    else if (flush) fetch_pc <= flush_addr;
    else if (push)  fetch_pc <= fetch_pc + ADDR_W'(1);
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({fetch_pc, imem_data}),
    .head  (head),
    .count (count)
  );

  // Head comes from storage only; forced to zero while empty.
  assign out_pc    = out_valid ? head[DATA_W-1:INSTR_W] : '0;
  assign out_instr = out_valid ? head[INSTR_W-1:0]      : '0;

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Directed bench for instruction_prefetch_buffer with a 16-word instruction memory model.
module tb_instruction_prefetch_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] imem_addr;
  logic [7:0] imem_data;
  logic       flush;
  logic [3:0] flush_addr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_instr;
  logic [3:0] out_pc;
  logic [2:0] count;

  logic [7:0] prog [16];
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign imem_data = prog[imem_addr];

  instruction_prefetch_buffer #(.DEPTH(4), .ADDR_W(4), .INSTR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .flush      (flush),
    .flush_addr (flush_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .count      (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; flush_addr = 4'd0; out_ready = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b1; flush_addr = 4'd7; out_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({out_valid, count, out_instr, out_pc, imem_addr} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset: valid=%0b count=%0d instr=%h pc=%0d addr=%0d expected all 0",
               out_valid, count, out_instr, out_pc, imem_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_instr !== prog[i % 16] || out_pc !== 4'(i % 16)
          || count !== 3'd1) begin
        n_fail++;
        $display("FAIL stream[%0d]: valid=%0b instr=%h pc=%0d count=%0d expected 1/%h/%0d/1",
                 i, out_valid, out_instr, out_pc, count, prog[i % 16], i % 16);
      end
    end
  endtask

  task automatic test_fill_and_drain();
    logic [2:0] exp_cnt [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (count !== exp_cnt[i]) begin
        n_fail++;
        $display("FAIL fill_count[%0d]: count=%0d expected %0d", i, count, exp_cnt[i]);
      end
    end
    n_cmp++;
    if (imem_addr !== 4'd4 || out_instr !== 8'hAB || out_pc !== 4'd0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_head: addr=%0d instr=%h pc=%0d valid=%0b expected 4/AB/0/1",
               imem_addr, out_instr, out_pc, out_valid);
    end
    // single-cycle ready pulse on a full buffer
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (count !== 3'd4 || out_instr !== 8'hDE || out_pc !== 4'd1 || imem_addr !== 4'd5) begin
      n_fail++;
      $display("FAIL full_pulse: count=%0d instr=%h pc=%0d addr=%0d expected 4/DE/1/5",
               count, out_instr, out_pc, imem_addr);
    end
    tick();
    n_cmp++;
    if (count !== 3'd4 || out_instr !== 8'hDE || imem_addr !== 4'd5) begin
      n_fail++;
      $display("FAIL full_hold: count=%0d instr=%h addr=%0d expected 4/DE/5",
               count, out_instr, imem_addr);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      n_cmp++;
      if (out_instr !== prog[i] || out_pc !== 4'(i) || count !== 3'd4) begin
        n_fail++;
        $display("FAIL drain[%0d]: instr=%h pc=%0d count=%0d expected %h/%0d/4",
                 i, out_instr, out_pc, count, prog[i], i);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if (count !== 3'd3) begin
      n_fail++;
      $display("FAIL pre_flush_count: count=%0d expected 3", count);
    end
    out_ready = 1'b1; flush = 1'b1; flush_addr = 4'd9;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 4'd9 || out_instr !== 8'h00) begin
      n_fail++;
      $display("FAIL flush_next: count=%0d valid=%0b addr=%0d instr=%h expected 0/0/9/00",
               count, out_valid, imem_addr, out_instr);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_instr !== 8'hD4 || out_pc !== 4'd9) begin
      n_fail++;
      $display("FAIL flush_first: valid=%0b instr=%h pc=%0d expected 1/D4/9",
               out_valid, out_instr, out_pc);
    end
    // flush held over several cycles keeps reloading fetch_pc
    flush = 1'b1; flush_addr = 4'd5;
    tick();
    flush_addr = 4'd12;
    tick();
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 4'd12) begin
      n_fail++;
      $display("FAIL flush_held: count=%0d valid=%0b addr=%0d expected 0/0/12",
               count, out_valid, imem_addr);
    end
    flush = 1'b0;
    tick();
    n_cmp++;
    if (out_instr !== prog[12] || out_pc !== 4'd12 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL flush_release: instr=%h pc=%0d count=%0d expected %h/12/1",
               out_instr, out_pc, count, prog[12]);
    end
  endtask

  task automatic test_ready_when_empty();
    flush = 1'b1; flush_addr = 4'd2; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    n_cmp++;
    if (count !== 3'd1 || out_instr !== 8'h3C || out_pc !== 4'd2 || imem_addr !== 4'd3) begin
      n_fail++;
      $display("FAIL ready_empty: count=%0d instr=%h pc=%0d addr=%0d expected 1/3C/2/3",
               count, out_instr, out_pc, imem_addr);
    end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (count !== 3'd4) begin
      n_fail++;
      $display("FAIL mid_pre_count: count=%0d expected 4", count);
    end
    rst = 1'b0; out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({out_valid, count, out_instr, out_pc, imem_addr} !== 20'd0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%0b count=%0d instr=%h pc=%0d addr=%0d expected all 0",
               out_valid, count, out_instr, out_pc, imem_addr);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_instr !== 8'hAB || out_pc !== 4'd0 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL mid_restart: valid=%0b instr=%h pc=%0d count=%0d expected 1/AB/0/1",
               out_valid, out_instr, out_pc, count);
    end
  endtask

  initial begin
    prog = '{8'hAB, 8'hDE, 8'h3C, 8'hD6, 8'hBC, 8'hCD, 8'hAE, 8'hA1,
             8'hB2, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18, 8'h29, 8'h88};
    rst = 1'b0; flush = 1'b0; flush_addr = 4'd0; out_ready = 1'b0;
    #1;
    test_reset();
    test_stream();
    test_fill_and_drain();
    test_flush();
    test_ready_when_empty();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
